// File: rtl/gige_tx_encap_pkg.sv
// Shared constants and types for the GigE transmit encapsulation stage.
package gige_tx_encap_pkg;

    localparam int MIN_BYTES = 60;
    localparam int MAX_BYTES = 1514;

    typedef logic [15:0] len_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PRESENT,
        ST_XFER
    } rd_state_t;

    function automatic logic [7:0] qwords(input len_t n);
        return 8'((n + 16'd7) >> 3);
    endfunction

endpackage

// File: rtl/gige_tx_pktbuf.sv
// Packet buffer: simple dual-port RAM, one write port, registered read port.
module gige_tx_pktbuf #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk125,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [63:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [63:0]   rd_data
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk125) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/gige_tx_encap.sv
// Frame buffer ahead of the GMII serializer: stores host frames, drops bad
// ones, pads runts and hands out one frame at a time with per-qword advance.
module gige_tx_encap #(
    parameter int DEPTH_QW  = 512,
    parameter int NFRAMES   = 8,
    parameter int MIN_BYTES = gige_tx_encap_pkg::MIN_BYTES,
    parameter int MAX_BYTES = gige_tx_encap_pkg::MAX_BYTES
) (
    input  logic        clk125,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [63:0] wr_data,
    input  logic        wr_sop,
    input  logic        wr_eop,
    input  logic [2:0]  wr_bytes,
    input  logic        wr_abort,
    output logic        wr_rdy,
    output logic        rts,
    input  logic        cts,
    input  logic        rd_next,
    output logic [63:0] rdata,
    output logic [15:0] rbytes,
    output logic [31:0] tx_frm_cnt,
    output logic [31:0] tx_drop_cnt
);
    import gige_tx_encap_pkg::*;

    localparam int AW = $clog2(DEPTH_QW);
    localparam int PW = AW + 1;
    localparam int FW = $clog2(NFRAMES);
    localparam logic [7:0] MAX_QW = 8'((MAX_BYTES + 7) / 8);

    // Pointers carry one wrap bit so a full buffer is distinguishable from empty.
    logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr, used, base;
    logic [FW:0]   lf_wp, lf_rp;
    logic [10:0]   lf_mem [NFRAMES];
    logic [10:0]   lf_head;
    logic          lf_full, lf_empty;

    logic          frm_open, take, store, over, commit, drop_inc;
    logic [7:0]    qw_cnt, qn;
    logic [11:0]   eop_len;

    rd_state_t     state, state_nx;
    logic [7:0]    k, nq, sq;
    logic [2:0]    lrem;
    logic          last;
    len_t          head_len, pad_len;
    logic [63:0]   ram_q;

    assign used     = wr_ptr - rd_ptr;
    assign lf_full  = (lf_wp - lf_rp) == (FW+1)'(NFRAMES);
    assign lf_empty = lf_wp == lf_rp;
    assign lf_head  = lf_mem[lf_rp[FW-1:0]];
    assign wr_rdy   = !rst && (used != PW'(DEPTH_QW)) && !lf_full;

    // qw_cnt saturates one past MAX_QW so an overlong frame stays marked.
    always_comb begin
        take     = wr_en && wr_rdy && (wr_sop || frm_open);
        qn       = wr_sop ? 8'd1 : ((qw_cnt > MAX_QW) ? qw_cnt : qw_cnt + 8'd1);
        over     = qn > MAX_QW;
        base     = wr_sop ? cm_ptr : wr_ptr;
        store    = take && !wr_abort && !over;
        eop_len  = {1'b0, qn - 8'd1, 3'b000}
                 + ((wr_bytes == 3'd0) ? 12'd8 : {9'd0, wr_bytes});
        commit   = take && !wr_abort && wr_eop && !over && (eop_len <= 12'(MAX_BYTES));
        drop_inc = (wr_abort && frm_open)
                 || (take && !wr_abort && ((wr_sop && frm_open) || (wr_eop && !commit)));
    end

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            cm_ptr      <= '0;
            frm_open    <= 1'b0;
            qw_cnt      <= '0;
            lf_wp       <= '0;
            tx_drop_cnt <= '0;
        end else begin
            if (drop_inc)
                tx_drop_cnt <= tx_drop_cnt + 32'd1;
            if (wr_abort) begin
                wr_ptr   <= cm_ptr;
                frm_open <= 1'b0;
            end else if (take) begin
                qw_cnt   <= qn;
                frm_open <= !wr_eop;
                if (wr_eop && !commit)
                    wr_ptr <= cm_ptr;
                else
                    wr_ptr <= store ? base + 1'b1 : base;
                if (commit) begin
                    cm_ptr <= base + 1'b1;
                    lf_wp  <= lf_wp + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk125) begin
        if (commit)
            lf_mem[lf_wp[FW-1:0]] <= eop_len[10:0];
    end

    gige_tx_pktbuf #(.DEPTH(DEPTH_QW), .AW(AW)) u_buf (
        .clk125  (clk125),
        .wr_en   (store),
        .wr_addr (base[AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[AW-1:0] + AW'(k)),
        .rd_data (ram_q)
    );

    assign head_len = len_t'(lf_head);
    assign pad_len  = (head_len < len_t'(MIN_BYTES)) ? len_t'(MIN_BYTES) : head_len;
    assign last     = (state == ST_XFER) && rd_next && (k == nq - 8'd1);

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        rts      = 1'b0;
        case (state)
            ST_IDLE:    if (!lf_empty) state_nx = ST_LOAD;
            ST_LOAD:    state_nx = ST_PRESENT;
            ST_PRESENT: begin
                rts = 1'b1;
                if (cts) state_nx = ST_XFER;
            end
            ST_XFER: begin
                rts = 1'b1;
                if (last) state_nx = ST_IDLE;
            end
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            lf_rp      <= '0;
            k          <= '0;
            nq         <= '0;
            sq         <= '0;
            lrem       <= '0;
            rbytes     <= '0;
            tx_frm_cnt <= '0;
        end else begin
            if (state == ST_LOAD) begin
                rbytes <= pad_len;
                nq     <= qwords(pad_len);
                sq     <= qwords(head_len);
                lrem   <= lf_head[2:0];
                k      <= '0;
            end
            if (state == ST_XFER && rd_next) begin
                if (last) begin
                    lf_rp      <= lf_rp + 1'b1;
                    rd_ptr     <= rd_ptr + PW'(sq);
                    tx_frm_cnt <= tx_frm_cnt + 32'd1;
                    k          <= '0;
                end else begin
                    k <= k + 8'd1;
                end
            end
        end
    end

    // Bytes past the frame end in the last stored qword, and all pad qwords, read as zero.
    always_comb begin
        rdata = '0;
        if (rts && k < sq) begin
            rdata = ram_q;
            if (k == sq - 8'd1 && lrem != 3'd0)
                for (int b = 0; b < 8; b++)
                    if (b >= int'(lrem))
                        rdata[b*8 +: 8] = 8'h00;
        end
    end

endmodule
